l1i_miss_handler: RTL and testbench

Services L1I cache misses and is the refill end of the L1I miss/update interface. It queues line misses raised by the cache, merging duplicates. For each queued line it issues one line-aligned read to the memory side, collects the line as 64-bit beats, then drives a single-cycle cache update carrying the line, address, Pid and Tid back into the L1I.

---
 rtl/l1i_pkg.sv | 39 +++
 rtl/l1i_miss_queue.sv | 69 ++++++
 rtl/l1i_miss_handler.sv | 146 ++++++++++++++
 tb/tb_l1i_miss_handler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1i_pkg.sv
// Shared widths, FSM states and the miss-entry layout for the L1I refill path.
// Pure declarations; no logic or latency of its own.
// Not applicable: no handshakes live here.
package l1i_pkg;

  localparam int ADDR_W         = 64;
  localparam int LINE_W         = 512;
  localparam int OFFSET_W       = 6;
  localparam int BEAT_W         = 64;
  localparam int PID_W          = 20;
  localparam int TID_W          = 16;
  localparam int MAJOR_W        = 64;
  localparam int QUEUE_DEPTH    = 4;
  localparam int BEATS_PER_LINE = LINE_W / BEAT_W;
  localparam int BEAT_CNT_W     = $clog2(BEATS_PER_LINE);
  localparam int QPTR_W         = $clog2(QUEUE_DEPTH);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    UPDATE
  } fsm_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  lineAddr;
    logic [PID_W-1:0]   pid;
    logic [TID_W-1:0]   tid;
    logic [MAJOR_W-1:0] majorId;
  } miss_entry_t;

  // Clears the byte offset so every address names a whole cache line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & LINE_MASK;
  endfunction

endpackage

// File: rtl/l1i_miss_queue.sv
// Circular miss FIFO with a parallel line-address lookup across all live entries.
// Push/pop take effect on the clock edge; match/head/full/empty reflect registered state.
// A push while full is ignored unless a pop frees the slot on the same edge.
module l1i_miss_queue
  import l1i_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  miss_entry_t        push_entry_i,
  input  logic               pop_i,
  input  logic [ADDR_W-1:0]  lookup_addr_i,
  output logic               full_o,
  output logic               empty_o,
  output logic               match_o,
  output miss_entry_t        head_o
);

  miss_entry_t         entries_q [QUEUE_DEPTH];
  logic [QPTR_W-1:0]   head_q, head_d;
  logic [QPTR_W-1:0]   tail_q, tail_d;
  logic [QPTR_W:0]     count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == (QPTR_W+1)'(QUEUE_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = entries_q[head_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    head_d  = head_q + QPTR_W'(do_pop);
    tail_d  = tail_q + QPTR_W'(do_push);
    count_d = count_q + {{QPTR_W{1'b0}}, do_push} - {{QPTR_W{1'b0}}, do_pop};
  end

  // An entry is live when its distance from head is below count; only live entries can match.
  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (({1'b0, QPTR_W'(i) - head_q} < count_q) &&
          (entries_q[i].lineAddr == lookup_addr_i)) begin
        match_o = 1'b1;
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while covered by head/count.
  always_ff @(posedge clock_i) begin
    if (do_push) begin
      entries_q[tail_q] <= push_entry_i;
    end
  end

endmodule

// File: rtl/l1i_miss_handler.sv
// Queues L1I line misses (merging duplicates), fetches each line in 8 beats, and fills the L1I.
// Minimum latency: miss edge -> request 2 cycles later; 8 beats later -> one-cycle update.
// Request held until memReqReady_i; beats accepted only while memRespValid_i; misses dropped when full.
module l1i_miss_handler
  import l1i_pkg::*;
(
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                cacheMiss_i,
  input  logic [ADDR_W-1:0]   missedAddress_i,
  input  logic [MAJOR_W-1:0]  missedInstMajorId_i,
  input  logic [PID_W-1:0]    missedPid_i,
  input  logic [TID_W-1:0]    missedTid_i,
  output logic                memReqValid_o,
  input  logic                memReqReady_i,
  output logic [ADDR_W-1:0]   memReqAddress_o,
  input  logic                memRespValid_i,
  input  logic [BEAT_W-1:0]   memRespData_i,
  output logic                cacheUpdate_o,
  output logic [ADDR_W-1:0]   cacheUpdateAddress_o,
  output logic [LINE_W-1:0]   cacheUpdateLine_o,
  output logic [PID_W-1:0]    cacheUpdatePid_o,
  output logic [TID_W-1:0]    cacheUpdateTid_o,
  output logic                missQueueFull_o,
  output logic                missDropped_o
);

  fsm_state_e              state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [ADDR_W-1:0]       req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]       upd_addr_q, upd_addr_d;
  logic [LINE_W-1:0]       upd_line_q, upd_line_d;
  logic [PID_W-1:0]        upd_pid_q, upd_pid_d;
  logic [TID_W-1:0]        upd_tid_q, upd_tid_d;
  logic                    dropped_q, dropped_d;

  logic                    q_push, q_pop, q_full, q_empty, q_match;
  miss_entry_t             q_head, new_entry;
  logic                    unused_major;

  assign new_entry = '{lineAddr: line_align(missedAddress_i), pid: missedPid_i,
                       tid: missedTid_i, majorId: missedInstMajorId_i};

  // The head is popped only at the end of UPDATE, so a re-miss to the in-flight line merges.
  assign q_pop     = (state_q == UPDATE);
  assign q_push    = cacheMiss_i && !q_match;
  assign dropped_d = cacheMiss_i && !q_match && q_full && !q_pop;

  // The major ID travels with the entry but nothing downstream consumes it yet.
  assign unused_major = ^q_head.majorId;

  l1i_miss_queue u_queue (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .push_i        (q_push),
    .push_entry_i  (new_entry),
    .pop_i         (q_pop),
    .lookup_addr_i (new_entry.lineAddr),
    .full_o        (q_full),
    .empty_o       (q_empty),
    .match_o       (q_match),
    .head_o        (q_head)
  );

  // Next-state and datapath: request the head, collect beats MSB-first, latch the fill on the last beat.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    line_d     = line_q;
    req_addr_d = req_addr_q;
    upd_addr_d = upd_addr_q;
    upd_line_d = upd_line_q;
    upd_pid_d  = upd_pid_q;
    upd_tid_d  = upd_tid_q;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          req_addr_d = q_head.lineAddr;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (memReqReady_i) begin
          beat_d  = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (memRespValid_i) begin
          for (int b = 0; b < BEATS_PER_LINE; b++) begin
            if (beat_q == BEAT_CNT_W'(b)) begin
              line_d[LINE_W-1-b*BEAT_W -: BEAT_W] = memRespData_i;
            end
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_CNT_W'(BEATS_PER_LINE-1)) begin
            upd_line_d = line_d;
            upd_addr_d = req_addr_q;
            upd_pid_d  = q_head.pid;
            upd_tid_d  = q_head.tid;
            state_d    = UPDATE;
          end
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partially collected line.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      line_q     <= '0;
      req_addr_q <= '0;
      upd_addr_q <= '0;
      upd_line_q <= '0;
      upd_pid_q  <= '0;
      upd_tid_q  <= '0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      req_addr_q <= req_addr_d;
      upd_addr_q <= upd_addr_d;
      upd_line_q <= upd_line_d;
      upd_pid_q  <= upd_pid_d;
      upd_tid_q  <= upd_tid_d;
      dropped_q  <= dropped_d;
    end
  end

  assign memReqValid_o        = (state_q == REQ);
  assign memReqAddress_o      = req_addr_q;
  assign cacheUpdate_o        = (state_q == UPDATE);
  assign cacheUpdateAddress_o = upd_addr_q;
  assign cacheUpdateLine_o    = upd_line_q;
  assign cacheUpdatePid_o     = upd_pid_q;
  assign cacheUpdateTid_o     = upd_tid_q;
  assign missQueueFull_o      = q_full;
  assign missDropped_o        = dropped_q;

endmodule

// File: tb/tb_l1i_miss_handler.sv
// Directed bench for l1i_miss_handler with a transaction-level reference model.
// Inputs change 1 time unit after the rising edge; the model compares on falling edges.
// Memory handshakes are driven by fixed per-test patterns.
module tb_l1i_miss_handler;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         cacheMiss_i = 1'b0;
  logic [63:0]  missedAddress_i = '0;
  logic [63:0]  missedInstMajorId_i = '0;
  logic [19:0]  missedPid_i = '0;
  logic [15:0]  missedTid_i = '0;
  logic         memReqValid_o;
  logic         memReqReady_i = 1'b0;
  logic [63:0]  memReqAddress_o;
  logic         memRespValid_i = 1'b0;
  logic [63:0]  memRespData_i = '0;
  logic         cacheUpdate_o;
  logic [63:0]  cacheUpdateAddress_o;
  logic [511:0] cacheUpdateLine_o;
  logic [19:0]  cacheUpdatePid_o;
  logic [15:0]  cacheUpdateTid_o;
  logic         missQueueFull_o;
  logic         missDropped_o;

  always #5 clock_i = ~clock_i;

  l1i_miss_handler dut (
    .clock_i(clock_i), .reset_i(reset_i), .cacheMiss_i(cacheMiss_i),
    .missedAddress_i(missedAddress_i), .missedInstMajorId_i(missedInstMajorId_i),
    .missedPid_i(missedPid_i), .missedTid_i(missedTid_i),
    .memReqValid_o(memReqValid_o), .memReqReady_i(memReqReady_i),
    .memReqAddress_o(memReqAddress_o), .memRespValid_i(memRespValid_i),
    .memRespData_i(memRespData_i), .cacheUpdate_o(cacheUpdate_o),
    .cacheUpdateAddress_o(cacheUpdateAddress_o), .cacheUpdateLine_o(cacheUpdateLine_o),
    .cacheUpdatePid_o(cacheUpdatePid_o), .cacheUpdateTid_o(cacheUpdateTid_o),
    .missQueueFull_o(missQueueFull_o), .missDropped_o(missDropped_o)
  );

  int nchk = 0;
  int nerr = 0;

  function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] a;
    logic [19:0] pid;
    logic [15:0] tid;
  } ment_t;

  ment_t        mq[$];
  ment_t        ne;
  int           ph = 0;      // 0 idle, 1 request, 2 collecting, 3 fill cycle
  int           ph_n;
  int           nb = 0;
  logic [63:0]  beats[8];
  bit           exp_drop = 0, mon_en = 0, hit, popping;
  logic [63:0]  la, exp_ra = '0, exp_ua = '0;
  logic [19:0]  exp_pid = '0;
  logic [15:0]  exp_tid = '0;
  logic [511:0] exp_line = '0;
  int           nreq = 0, nupd = 0;
  logic [63:0]  upd_log[$];

  always @(posedge clock_i) begin
    if (reset_i) begin
      mq.delete();
      ph = 0; nb = 0; exp_drop = 0;
      exp_ra = '0; exp_ua = '0; exp_pid = '0; exp_tid = '0; exp_line = '0;
      mon_en = 1;
    end else begin
      popping = (ph == 3);
      ph_n = ph;
      case (ph)
        0: if (mq.size() != 0) begin ph_n = 1; exp_ra = mq[0].a; end
        1: if (memReqReady_i) begin ph_n = 2; nb = 0; end
        2: if (memRespValid_i) begin
             beats[nb] = memRespData_i;
             nb++;
             if (nb == 8) begin
               ph_n = 3;
               exp_line = '0;
               for (int i = 0; i < 8; i++) exp_line = {exp_line[447:0], beats[i]};
               exp_ua = mq[0].a; exp_pid = mq[0].pid; exp_tid = mq[0].tid;
             end
           end
        default: ph_n = 0;
      endcase
      exp_drop = 0;
      if (cacheMiss_i) begin
        la = missedAddress_i & ~64'h3f;
        hit = 0;
        foreach (mq[i]) if (mq[i].a == la) hit = 1;
        if (!hit) begin
          if (mq.size() < 4 || popping) begin
            ne.a = la; ne.pid = missedPid_i; ne.tid = missedTid_i;
            mq.push_back(ne);
          end else begin
            exp_drop = 1;
          end
        end
      end
      if (popping) void'(mq.pop_front());
      ph = ph_n;
    end
  end

  always @(negedge clock_i) begin
    if (mon_en) begin
      chk("memReqValid", memReqValid_o, ph == 1);
      chk("memReqAddress", memReqAddress_o, exp_ra);
      chk("cacheUpdate", cacheUpdate_o, ph == 3);
      chk("updAddress", cacheUpdateAddress_o, exp_ua);
      chk("updPid", cacheUpdatePid_o, exp_pid);
      chk("updTid", cacheUpdateTid_o, exp_tid);
      chk("updLine", cacheUpdateLine_o, exp_line);
      chk("queueFull", missQueueFull_o, mq.size() == 4);
      chk("missDropped", missDropped_o, exp_drop);
      if (memReqValid_o && memReqReady_i) nreq++;
      if (cacheUpdate_o) begin
        nupd++;
        upd_log.push_back(cacheUpdateAddress_o);
      end
    end
  end

  // ---------------- stimulus ----------------
  int cyc = 0;
  int got, r0, u0, l0;
  int vp[5] = '{1, 0, 1, 1, 0};
  logic [63:0]  ord3[4] = '{64'h000, 64'h040, 64'h080, 64'h0C0};
  logic [63:0]  ord6[5] = '{64'h400, 64'h440, 64'h480, 64'h4C0, 64'h200};
  logic [511:0] t4_line;
  localparam logic [511:0] T1_LINE = {64'h1111111111111111, 64'h2222222222222222,
                                      64'h3333333333333333, 64'h4444444444444444,
                                      64'h5555555555555555, 64'h6666666666666666,
                                      64'h7777777777777777, 64'h8888888888888888};

  task automatic step();
    @(posedge clock_i);
    #1;
    cyc++;
    memRespData_i = {32'hC0DE0000, cyc};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic miss(input logic [63:0] a, input logic [19:0] p, input logic [15:0] t);
    cacheMiss_i = 1'b1; missedAddress_i = a; missedPid_i = p; missedTid_i = t;
    missedInstMajorId_i = {32'h0, cyc};
    step();
    cacheMiss_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_reqvld"}, memReqValid_o, 1'b0);
    chk({tag, "_reqaddr"}, memReqAddress_o, 64'h0);
    chk({tag, "_upd"}, cacheUpdate_o, 1'b0);
    chk({tag, "_updaddr"}, cacheUpdateAddress_o, 64'h0);
    chk({tag, "_updline"}, cacheUpdateLine_o, 512'h0);
    chk({tag, "_full"}, missQueueFull_o, 1'b0);
    chk({tag, "_drop"}, missDropped_o, 1'b0);
  endtask

  initial begin
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_outputs_zero("reset");

    // single miss, minimum latency
    memReqReady_i = 1'b1;
    miss(64'h44, 20'd3, 16'd1);
    step();
    chk("t1_reqvld", memReqValid_o, 1'b1);
    chk("t1_reqaddr", memReqAddress_o, 64'h40);
    step();
    memRespValid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      memRespData_i = 64'h1111111111111111 * 64'(i + 1);
      step();
    end
    memRespValid_i = 1'b0;
    chk("t1_upd", cacheUpdate_o, 1'b1);
    chk("t1_addr", cacheUpdateAddress_o, 64'h40);
    chk("t1_line", cacheUpdateLine_o, T1_LINE);
    chk("t1_pid", cacheUpdatePid_o, 20'd3);
    chk("t1_tid", cacheUpdateTid_o, 16'd1);
    step();
    chk("t1_pulse", cacheUpdate_o, 1'b0);
    idle(3);

    // merge of three misses to the same line
    r0 = nreq; u0 = nupd;
    memRespValid_i = 1'b1;
    miss(64'h80, 20'd4, 16'd2);
    miss(64'h84, 20'd5, 16'd3);
    miss(64'hBC, 20'd6, 16'd4);
    idle(20);
    chk("t2_nreq", nreq - r0, 1);
    chk("t2_nupd", nupd - u0, 1);
    chk("t2_addr", upd_log[$], 64'h80);

    // overflow with memory stalled
    memReqReady_i = 1'b0;
    l0 = upd_log.size();
    miss(64'h000, 20'd10, 16'd0);
    miss(64'h040, 20'd11, 16'd1);
    miss(64'h080, 20'd12, 16'd2);
    miss(64'h0C0, 20'd13, 16'd3);
    chk("t3_full", missQueueFull_o, 1'b1);
    miss(64'h100, 20'd14, 16'd4);
    chk("t3_drop", missDropped_o, 1'b1);
    memReqReady_i = 1'b1;
    idle(60);
    chk("t3_count", upd_log.size() - l0, 4);
    for (int i = 0; i < 4; i++)
      if (l0 + i < upd_log.size()) chk("t3_order", upd_log[l0 + i], ord3[i]);

    // stalled handshake and gapped beats
    memReqReady_i = 1'b0; memRespValid_i = 1'b0;
    miss(64'h1C4, 20'd7, 16'd9);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_vld", memReqValid_o, 1'b1);
      chk("t4_stall_addr", memReqAddress_o, 64'h1C0);
      step();
    end
    memReqReady_i = 1'b1;
    chk("t4_hold_addr", memReqAddress_o, 64'h1C0);
    step();
    got = 0;
    t4_line = '0;
    for (int i = 0; i < 20; i++) begin
      if (got < 8) begin
        memRespValid_i = vp[i % 5][0];
        memRespData_i = 64'hA5A5000000000000 | 64'(got);
        if (vp[i % 5] == 1) begin
          t4_line = {t4_line[447:0], 64'hA5A5000000000000 | 64'(got)};
          got++;
        end
        step();
        memRespValid_i = 1'b0;
        chk("t4_upd_timing", cacheUpdate_o, got == 8);
      end
    end
    chk("t4_line", cacheUpdateLine_o, t4_line);
    chk("t4_addr", cacheUpdateAddress_o, 64'h1C0);
    chk("t4_pid", cacheUpdatePid_o, 20'd7);
    idle(3);

    // reset in the middle of beat collection
    u0 = nupd;
    miss(64'h304, 20'd5, 16'd5);
    step();
    step();
    memRespValid_i = 1'b1;
    idle(3);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_outputs_zero("t5_after_reset");
    idle(4);
    memRespValid_i = 1'b0;
    chk("t5_no_upd", nupd - u0, 0);
    chk("t5_idle", memReqValid_o, 1'b0);
    memRespValid_i = 1'b1;
    miss(64'h344, 20'd6, 16'd6);
    idle(15);
    chk("t5_fresh_nupd", nupd - u0, 1);
    chk("t5_fresh_addr", upd_log[$], 64'h340);

    // full queue plus a distinct miss on the pop edge
    l0 = upd_log.size();
    miss(64'h400, 20'd1, 16'd1);
    miss(64'h440, 20'd2, 16'd2);
    miss(64'h480, 20'd3, 16'd3);
    miss(64'h4C0, 20'd4, 16'd4);
    idle(7);
    chk("t6_upd", cacheUpdate_o, 1'b1);
    chk("t6_full", missQueueFull_o, 1'b1);
    miss(64'h200, 20'd8, 16'd8);
    chk("t6_nodrop", missDropped_o, 1'b0);
    chk("t6_still_full", missQueueFull_o, 1'b1);
    idle(60);
    chk("t6_count", upd_log.size() - l0, 5);
    for (int i = 0; i < 5; i++)
      if (l0 + i < upd_log.size()) chk("t6_order", upd_log[l0 + i], ord6[i]);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
